// File: rtl/topk_sorted_heap_if.sv
// Insert, read-out and eviction signal bundle for topk_sorted_heap.
// The slave side is the heap itself; the master side is the surrounding logic or a testbench.
interface topk_sorted_heap_if #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int DEPTH       = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [KEY_WIDTH-1:0]   in_key;
    logic [VALUE_WIDTH-1:0] in_value;
    logic                   in_valid;
    logic                   in_ready;
    logic                   rd_req;
    logic                   rd_clear;
    logic [KEY_WIDTH-1:0]   out_key;
    logic [VALUE_WIDTH-1:0] out_value;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [KEY_WIDTH-1:0]   evict_key;
    logic [VALUE_WIDTH-1:0] evict_value;
    logic                   evict_valid;
    logic [CNT_W-1:0]       count;

    modport master (
        output in_key, in_value, in_valid, rd_req, rd_clear, out_ready,
        input  in_ready, out_key, out_value, out_last, out_valid,
               evict_key, evict_value, evict_valid, count
    );

    modport slave (
        input  in_key, in_value, in_valid, rd_req, rd_clear, out_ready,
        output in_ready, out_key, out_value, out_last, out_valid,
               evict_key, evict_value, evict_valid, count
    );
endinterface

// File: rtl/topk_sorted_heap.sv
// Top-K key/value array kept sorted by value (descending); overflow evicts the smallest pair.
// Insert visible 2 cycles after accept (1 per 2 cycles); read-out stalls on out_ready and blocks inserts.
module topk_sorted_heap #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int DEPTH       = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    topk_sorted_heap_if.slave    bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_READ} state_t;

    state_t           state_q, state_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             clr_q, clr_d;
    entry_t           new_q, new_d;
    entry_t           evict_q, evict_d;
    logic             evict_vld_q, evict_vld_d;

    logic             in_rdy;
    logic             out_vld;
    logic             out_lst;
    entry_t           rd_ent;
    logic             rd_fire;
    logic             read_done;

    logic             found;
    logic [DEPTH-1:0] gone;
    entry_t           rem [DEPTH];
    entry_t           upd [DEPTH];
    logic [CNT_W-1:0] rem_cnt;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] upd_cnt;
    logic             full;
    logic             ev_vld;
    entry_t           ev_ent;

    // Remove any key match, then splice the new pair in after all entries with value >= it.
    always_comb begin
        found = 1'b0;
        gone  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            found   = found | (vld_q[i] && (ent_q[i].key == new_q.key));
            gone[i] = found;
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            rem[i] = gone[i] ? ent_q[i+1] : ent_q[i];
        end
        rem[DEPTH-1] = gone[DEPTH-1] ? '0 : ent_q[DEPTH-1];

        rem_cnt = count_q - CNT_W'(found);
        pos     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < rem_cnt) && (rem[i].value >= new_q.value)) begin
                pos = pos + CNT_W'(1);
            end
        end

        upd[0] = (pos == '0) ? new_q : rem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (CNT_W'(i) < pos) begin
                upd[i] = rem[i];
            end else if (CNT_W'(i) == pos) begin
                upd[i] = new_q;
            end else begin
                upd[i] = rem[i-1];
            end
        end

        full    = (count_q == CNT_W'(DEPTH));
        ev_vld  = !found && full;
        ev_ent  = (pos == CNT_W'(DEPTH)) ? new_q : ent_q[DEPTH-1];
        upd_cnt = (found || full) ? count_q : count_q + CNT_W'(1);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rd_req) begin
                    state_d = S_READ;
                end else if (bus.in_valid) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            S_READ:   if (read_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state_q == S_IDLE) && !bus.rd_req;
        out_vld = (state_q == S_READ) && (idx_q < count_q);
        out_lst = out_vld && (idx_q == count_q - CNT_W'(1));
        rd_ent  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == idx_q) rd_ent = ent_q[i];
        end
        rd_fire   = out_vld && bus.out_ready;
        // An empty array has no beats, so READ ends on its first edge.
        read_done = (state_q == S_READ) && (!out_vld || (rd_fire && out_lst));
    end

    always_comb begin
        ent_d       = ent_q;
        count_d     = count_q;
        idx_d       = idx_q;
        clr_d       = clr_q;
        new_d       = new_q;
        evict_d     = evict_q;
        evict_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rd_req) begin
                    clr_d = bus.rd_clear;
                    idx_d = '0;
                end else if (bus.in_valid) begin
                    new_d = '{key: bus.in_key, value: bus.in_value};
                end
            end
            S_UPDATE: begin
                ent_d       = upd;
                count_d     = upd_cnt;
                evict_vld_d = ev_vld;
                if (ev_vld) evict_d = ev_ent;
            end
            S_READ: begin
                if (rd_fire) idx_d = idx_q + CNT_W'(1);
                if (read_done && clr_q) count_d = '0;
            end
            default: ;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            vld_d[i] = (CNT_W'(i) < count_d);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            clr_q       <= 1'b0;
            new_q       <= '0;
            evict_q     <= '0;
            evict_vld_q <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            vld_q       <= vld_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            clr_q       <= clr_d;
            new_q       <= new_d;
            evict_q     <= evict_d;
            evict_vld_q <= evict_vld_d;
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld;
    assign bus.out_last    = out_lst;
    assign bus.out_key     = rd_ent.key;
    assign bus.out_value   = rd_ent.value;
    assign bus.evict_valid = evict_vld_q;
    assign bus.evict_key   = evict_q.key;
    assign bus.evict_value = evict_q.value;
    assign bus.count       = count_q;
endmodule

// File: doc/topk_sorted_heap.md
Name: topk_sorted_heap

Overview:
- Parametrised, self-contained successor to the per-stage heavy-hitter heap in the CMS path.
- Holds up to DEPTH key/value entries, always sorted by value (descending, unsigned).
- Key-match updates move the entry to its new rank; a full array evicts its lowest entry. Evictions are reported on a side port.
- A streaming read-out port, with optional clear, replaces the old bubble-through AXI-lite read.

Parameters:
- KEY_WIDTH, 32, key width in bits
- VALUE_WIDTH, 32, value width in bits (unsigned compare)
- DEPTH, 8, number of entries; legal range 2..64
- Local CNT_W = $clog2(DEPTH+1).

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  synchronous reset, active-low
- in_key  in  KEY_WIDTH  key to insert/update
- in_value  in  VALUE_WIDTH  new value for in_key
- in_valid  in  1  insert request
- in_ready  out  1  insert accepted when in_valid&in_ready
- rd_req  in  1  start read-out (sampled in IDLE)
- rd_clear  in  1  sampled with rd_req; clear array after the last beat
- out_key  out  KEY_WIDTH  read-out key
- out_value  out  VALUE_WIDTH  read-out value
- out_last  out  1  marks the final read-out beat
- out_valid  out  1  read-out beat valid
- out_ready  in  1  read-out consumer ready
- evict_key  out  KEY_WIDTH  key pushed out of the array
- evict_value  out  VALUE_WIDTH  value pushed out of the array
- evict_valid  out  1  one-cycle eviction pulse
- count  out  CNT_W  number of valid entries

Behaviour:
- Reset (ap_rst_n==0 at an edge):
  - All entry valid bits, count, out_valid, out_last and evict_valid go to 0.
  - Key/value/out/evict data registers go to 0; FSM goes to IDLE.
  - Reset mid-insert or mid-read aborts it; nothing is emitted.
- Array invariant: entries 0..count-1 are valid with value[i] >= value[i+1]; entries >= count are invalid. Keys are unique.
- FSM states:
  - IDLE, UPDATE, READ.
  - in_ready = (state==IDLE) & !rd_req; read has priority over insert.
- IDLE:
  - rd_req=1: latch rd_clear, set idx=0, go to READ.
  - Else on in_valid&in_ready: latch key/value, go to UPDATE.
- UPDATE (one cycle; commit on the edge leaving it, back to IDLE):
  - Match m = index of valid entry with key==latched key (at most one).
  - Remove m if found.
  - Insert position p = number of remaining valid entries with value >= new value; on ties the new entry goes after the existing ones.
  - Entries p..end shift down one place.
  - Match found: count unchanged, no eviction; value may rise or fall.
  - No match, count<DEPTH: count+1, no eviction.
  - No match, count==DEPTH, p<DEPTH: old entry DEPTH-1 is evicted, count unchanged.
  - No match, count==DEPTH, p==DEPTH: the new pair itself is evicted; array unchanged.
  - evict_valid pulses for exactly one cycle, in the cycle after UPDATE, with the evicted pair.
- Timing:
  - Accept at cycle T; array/count are visible from T+2; the next accept is possible at T+2.
  - Peak throughput is 1 insert per 2 cycles.
- READ:
  - out_valid = (idx<count).
  - out_key/out_value = entry[idx]; out_last = (idx==count-1).
  - On out_valid&out_ready: idx+1. After the last beat, return to IDLE.
  - If rd_clear was latched, all valid bits clear and count=0 on that same edge.
  - count==0 at rd_req: no beats; return to IDLE on the next edge, and clear still applies (no-op).
  - Outputs hold stable while out_valid&!out_ready. Inserts are stalled for the whole READ (in_ready=0).
- Widths: value compare is full-width unsigned; no arithmetic on values. idx and count are CNT_W wide with no wrap.

Test Plan:
- Reset, DEPTH=4, insert (A,5),(B,9),(C,7) → count=3; read gives B9, C7, A5, out_last on A; no evict pulses.
- Full array B9,C7,A5,D3; insert (E,6) → order B9,C7,E6,A5; evict_valid pulse with (D,3) at T+2.
- Same full array; insert (F,2) → array unchanged; evict pulse (F,2). Then insert (G,7) → tie places it after C7; evicts (A,5).
- Update existing: insert (A,10) → A moves to index 0, count unchanged, no evict. Insert (A,1) → A moves to last place.
- Read with rd_clear=1 and out_ready toggled 1,0,0,1… → data holds during stalls; count=0 after last beat. rd_req with count=0 → no beats, back to IDLE.
- in_valid and rd_req together in IDLE → in_ready=0, read runs first, insert accepted after READ. ap_rst_n=0 during UPDATE → no evict pulse, count=0.
